bin_bcd_seq_conv: RTL and testbench
===================================

// Module: bin_bcd_seq_conv
// PURPOSE
//  Sequential binary-to-BCD converter using shift-and-add-3 (double dabble), generalised to BIN_W-bit inputs.
//  Supersedes the fixed 4-bit combinational binary/BCD decoder for wide counters feeding 7-segment displays.
//  Valid/ready on both sides; one conversion in flight; BIN_W shift cycles per conversion.
// PARAMETERS
//  BIN_W   16  width of binary input (4..32)
//  DIGITS  5   number of BCD output digits; elaboration $error if 10**DIGITS-1 < 2**BIN_W-1
// PORTS
//  clk        in   1          single clock, all state updates on rising edge
//  rst_n      in   1          reset, synchronous, active-low
//  in_valid   in   1          bin holds a value to convert
//  in_ready   out  1          converter idle, can accept bin
//  bin        in   BIN_W      binary input, unsigned (see CONFIGURATION)
//  out_valid  out  1          bcd result valid, held until out_ready
//  out_ready  in   1          sink accepts result
//  bcd        out  4*DIGITS   packed BCD, digit 0 (units) in bcd[3:0]
//  sign       out  1          only with BIN_BCD_SIGN_EN; result negative
// BEHAVIOUR
//  Reset (rst_n=0 at edge): state=IDLE, in_ready=1, out_valid=0, bcd=0, sign=0, count=0; mid-conversion work discarded.
//  FSM IDLE -> SHIFT: on in_valid&&in_ready; load shift reg={DIGITS*4'b0, bin}, count=0.
//  SHIFT: each cycle, every digit >=5 gets +3 (combinational), then whole {bcd,bin} shifts left 1; count++.
//   After BIN_W shifts (count==BIN_W-1 on the shifting edge) -> DONE.
//  DONE: out_valid=1, bcd stable; out_ready=1 -> IDLE next cycle, out_valid drops.
//  in_ready=1 only in IDLE; in_valid ignored otherwise (no queueing, no drop of accepted data).
//  Latency: accept edge to out_valid high = BIN_W+1 cycles; throughput one result per BIN_W+2 cycles with out_ready=1.
//  out_valid once high stays high and bcd unchanged until handshake (AXI-style, no retraction).
//  bcd/sign registered outputs; bcd updates only on entry to DONE, holds last value in IDLE.
//  Boundary: bin=0 -> all-zero digits; bin=2**BIN_W-1 -> exact decimal, no overflow possible given DIGITS check.
//  in_valid and out_ready both high in DONE: out handshake completes; new input not accepted until IDLE.
// CONFIGURATION
//  BIN_BCD_SIGN_EN defined: bin is two's complement; at accept, sign=bin[BIN_W-1], magnitude=|bin| as BIN_W-bit
//   unsigned (−2**(BIN_W-1) converts to 2**(BIN_W-1)); sign port present, registered with bcd.
//  Undefined: bin unsigned, sign port absent, no negation logic.
// STRUCTURE
//  Package bin_bcd_pkg: typedef enum logic[1:0] {IDLE,SHIFT,DONE} conv_state_t; localparam BCD_ADJ_THRESH=4'd5,
//   BCD_ADJ_ADD=4'd3; function bcd_digits_min(int bin_w) used in elaboration check.
//  Sub-module bcd_digit_adj: 4-bit in/out, d>=5 ? d+3 : d; instantiated DIGITS times via generate.
//  Counter width $clog2(BIN_W); shift register width 4*DIGITS+BIN_W.
// TESTING (BIN_W=16, DIGITS=5 unless noted)
//  1 bin=0, out_ready=1 -> out_valid after 17 cycles, bcd=20'h00000.
//  2 bin=16'hFFFF -> bcd=20'h65535; bin=15 -> bcd=20'h00015; sweep 0..15 matches legacy 4-bit table.
//  3 out_ready=0 for 10 cycles after out_valid -> bcd/out_valid stable, in_ready=0; then out_ready=1 -> IDLE next cycle.
//  4 back-to-back in_valid with 1234, 9999 -> results 0x01234, 0x09999 in order, 18 cycles apart, none lost.
//  5 rst_n=0 at shift 8 of 40000 -> next edge in_ready=1, out_valid=0, bcd=0; new input 7 -> bcd=0x00007.
//  6 BIN_BCD_SIGN_EN: bin=16'h8000 -> sign=1, bcd=0x32768; bin=16'hFFFF -> sign=1, bcd=0x00001; random vs model.

Source files
------------

// File: rtl/bin_bcd_pkg.sv
// Shared types, constants and elaboration helpers for the sequential binary-to-BCD converter.
package bin_bcd_pkg;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} conv_state_t;

  localparam logic [3:0] BCD_ADJ_THRESH = 4'd5;
  localparam logic [3:0] BCD_ADJ_ADD    = 4'd3;

  // Decimal digits needed to print the largest unsigned bin_w-bit value.
  function automatic int bcd_digits_min(int bin_w);
    longint unsigned v;
    int              n;
    v = (64'd1 << bin_w) - 64'd1;
    n = 1;
    for (int i = 0; i < 20; i++) begin
      if (v > 64'd9) begin
        v = v / 64'd10;
        n = n + 1;
      end
    end
    return n;
  endfunction

endpackage

// File: rtl/bcd_digit_adj.sv
// Double-dabble digit correction: add 3 to any BCD digit of 5 or more before the shift.
module bcd_digit_adj
  import bin_bcd_pkg::*;
(
  input  logic [3:0] i_d,
  output logic [3:0] o_d
);

  assign o_d = (i_d >= BCD_ADJ_THRESH) ? (i_d + BCD_ADJ_ADD) : i_d;

endmodule

// File: rtl/bin_bcd_seq_conv.sv
// Sequential shift-and-add-3 binary-to-BCD converter with valid/ready on both sides.
// Define BIN_BCD_SIGN_EN to treat bin as two's complement and expose the sign output.
module bin_bcd_seq_conv
  import bin_bcd_pkg::*;
#(
  parameter int BIN_W  = 16,
  parameter int DIGITS = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [BIN_W-1:0]      bin,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [4*DIGITS-1:0]   bcd
`ifdef BIN_BCD_SIGN_EN
  ,
  output logic                  sign
`endif
);

  localparam int SR_W  = 4*DIGITS + BIN_W;
  localparam int CNT_W = $clog2(BIN_W);

  generate
    if (BIN_W < 4 || BIN_W > 32) begin : g_width_chk
      $error("bin_bcd_seq_conv: BIN_W must be in 4..32");
    end
    if (DIGITS < bcd_digits_min(BIN_W)) begin : g_digits_chk
      $error("bin_bcd_seq_conv: DIGITS too small for BIN_W");
    end
  endgenerate

  conv_state_t          r_state;
  conv_state_t          w_state_next;
  logic [CNT_W-1:0]     r_count;
  logic [SR_W-1:0]      r_shift;
  logic [SR_W-1:0]      w_adj;
  logic [SR_W-1:0]      w_shifted;
  logic [4*DIGITS-1:0]  r_bcd;
  logic [BIN_W-1:0]     w_load_mag;
  logic                 w_accept;
  logic                 w_last_shift;

  generate
    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_adj
      bcd_digit_adj u_adj (
        .i_d (r_shift[BIN_W + 4*gi +: 4]),
        .o_d (w_adj[BIN_W + 4*gi +: 4])
      );
    end
  endgenerate

  assign w_adj[BIN_W-1:0] = r_shift[BIN_W-1:0];
  assign w_shifted        = w_adj << 1;
  assign w_accept         = in_valid && (r_state == IDLE);
  assign w_last_shift     = (r_count == CNT_W'(BIN_W - 1));

`ifdef BIN_BCD_SIGN_EN
  logic r_sign_pend;
  logic r_sign;

  // Most negative input maps onto itself, which reads correctly as unsigned magnitude.
  assign w_load_mag = bin[BIN_W-1] ? ((~bin) + BIN_W'(1)) : bin;
  assign sign       = r_sign;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_sign_pend <= 1'b0;
      r_sign      <= 1'b0;
    end else begin
      if (w_accept)
        r_sign_pend <= bin[BIN_W-1];
      if (r_state == SHIFT && w_last_shift)
        r_sign <= r_sign_pend;
    end
  end
`else
  assign w_load_mag = bin;
`endif

  always_comb begin
    w_state_next = r_state;
    in_ready     = 1'b0;
    out_valid    = 1'b0;
    unique case (r_state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid)
          w_state_next = SHIFT;
      end
      SHIFT: begin
        if (w_last_shift)
          w_state_next = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready)
          w_state_next = IDLE;
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n)
      r_state <= IDLE;
    else
      r_state <= w_state_next;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_count <= '0;
      r_shift <= '0;
      r_bcd   <= '0;
    end else if (w_accept) begin
      r_shift <= {{(4*DIGITS){1'b0}}, w_load_mag};
      r_count <= '0;
    end else if (r_state == SHIFT) begin
      r_shift <= w_shifted;
      r_count <= r_count + 1'b1;
      // Result register only moves on entry to DONE so it holds through IDLE.
      if (w_last_shift)
        r_bcd <= w_shifted[SR_W-1:BIN_W];
    end
  end

  assign bcd = r_bcd;

endmodule

// File: tb/tb_bin_bcd_seq_conv.sv
// Bench for bin_bcd_seq_conv (BIN_W=16, DIGITS=5): vector table, corner sequences, scoreboard.
module tb_bin_bcd_seq_conv;

  localparam int BIN_W  = 16;
  localparam int DIGITS = 5;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [15:0] bin = '0;
  logic        in_ready;
  logic        out_valid;
  logic [19:0] bcd;
  logic        sign_o;

  bin_bcd_seq_conv #(.BIN_W(BIN_W), .DIGITS(DIGITS)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .bin       (bin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .bcd       (bcd)
`ifdef BIN_BCD_SIGN_EN
    ,
    .sign      (sign_o)
`endif
  );

`ifndef BIN_BCD_SIGN_EN
  assign sign_o = 1'b0;
`endif

  always #5 clk = ~clk;

  typedef struct packed {
    logic        sgn;
    logic [19:0] val;
  } res_t;

  typedef struct {
    logic [15:0] bin;
    logic [19:0] bcd;
    logic        sgn;
  } vec_t;

  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  res_t exp_q[$];
  res_t got_q[$];
  int   got_cyc_q[$];
  int   done_cyc_q[$];
  vec_t vecs[8];

  always @(posedge clk) cyc++;

  // Capture each output handshake just after the falling edge, when inputs are settled.
  always @(negedge clk) begin
    #1;
    if (rst_n && out_valid && out_ready) begin
      got_q.push_back({sign_o, bcd});
      got_cyc_q.push_back(cyc);
    end
  end

  function automatic res_t model(input logic [15:0] b);
    res_t        r;
    logic [31:0] m;
    r.sgn = 1'b0;
    r.val = '0;
    m = {16'd0, b};
`ifdef BIN_BCD_SIGN_EN
    if (b[15]) begin
      r.sgn = 1'b1;
      m = 32'h10000 - {16'd0, b};
    end
`endif
    for (int i = 0; i < 5; i++) begin
      r.val[4*i +: 4] = 4'(m % 10);
      m = m / 10;
    end
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] expv);
    checks++;
    if (got !== expv) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, expv);
    end
  endtask

  task automatic send(input logic [15:0] b);
    int t;
    @(negedge clk);
    in_valid = 1'b1;
    bin = b;
    t = 0;
    while (!in_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready) begin
      chk("accept_timeout", 32'(in_ready), 32'd1);
      in_valid = 1'b0;
      return;
    end
    exp_q.push_back(model(b));
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int   t;
    res_t e;
    res_t g;
    while (exp_q.size() > 0) begin
      t = 0;
      while (got_q.size() == 0 && t < 200) begin
        @(negedge clk);
        t++;
      end
      if (got_q.size() == 0) begin
        chk("result_timeout", 32'(got_q.size()), 32'd1);
        exp_q.delete();
        return;
      end
      e = exp_q.pop_front();
      g = got_q.pop_front();
      done_cyc_q.push_back(got_cyc_q.pop_front());
      $display("xfer: sign=%0b bcd=%05h expected sign=%0b bcd=%05h", g.sgn, g.val, e.sgn, e.val);
      chk("result", 32'(g), 32'(e));
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int          n;
    logic [15:0] r;

    vecs[0] = '{16'd0,     20'h00000, 1'b0};
    vecs[1] = '{16'd15,    20'h00015, 1'b0};
    vecs[2] = '{16'd1234,  20'h01234, 1'b0};
    vecs[3] = '{16'd9999,  20'h09999, 1'b0};
    vecs[4] = '{16'd100,   20'h00100, 1'b0};
`ifdef BIN_BCD_SIGN_EN
    vecs[5] = '{16'hFFFF,  20'h00001, 1'b1};
    vecs[6] = '{16'h8000,  20'h32768, 1'b1};
    vecs[7] = '{16'd40000, 20'h25536, 1'b1};
`else
    vecs[5] = '{16'hFFFF,  20'h65535, 1'b0};
    vecs[6] = '{16'h8000,  20'h32768, 1'b0};
    vecs[7] = '{16'd40000, 20'h40000, 1'b0};
`endif

    repeat (3) @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_bcd", 32'(bcd), 32'd0);
    chk("rst_sign", 32'(sign_o), 32'd0);
    rst_n = 1'b1;
    out_ready = 1'b1;

    // Latency counted in rising edges, accept edge included.
    send(16'd0);
    n = 1;
    while (!out_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("latency", 32'(n), 32'd17);
    drain();

    for (int i = 0; i < 8; i++) begin
      send(vecs[i].bin);
      drain();
      @(negedge clk);
      chk("table_bcd_hold", 32'(bcd), 32'(vecs[i].bcd));
      chk("table_sign", 32'(sign_o), 32'(vecs[i].sgn));
    end

    for (int i = 0; i < 16; i++) begin
      send(16'(i));
      drain();
      chk("legacy_sweep", 32'(bcd), 32'(i + ((i >= 10) ? 6 : 0)));
    end

    done_cyc_q.delete();
    send(16'd1234);
    send(16'd9999);
    drain();
    if (done_cyc_q.size() == 2)
      chk("b2b_spacing", 32'(done_cyc_q[1] - done_cyc_q[0]), 32'd18);
    else
      chk("b2b_count", 32'(done_cyc_q.size()), 32'd2);

    out_ready = 1'b0;
    send(16'd12345);
    n = 0;
    while (!out_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("hold_valid_seen", 32'(out_valid), 32'd1);
    in_valid = 1'b1;
    bin = 16'd777;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("hold_out_valid", 32'(out_valid), 32'd1);
      chk("hold_bcd", 32'(bcd), 32'h12345);
      chk("hold_in_ready", 32'(in_ready), 32'd0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    chk("release_out_valid", 32'(out_valid), 32'd0);
    chk("release_in_ready", 32'(in_ready), 32'd1);
    drain();

    send(16'd40000);
    repeat (8) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk("midrst_in_ready", 32'(in_ready), 32'd1);
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_bcd", 32'(bcd), 32'd0);
    chk("midrst_sign", 32'(sign_o), 32'd0);
    rst_n = 1'b1;
    exp_q.delete();
    chk("midrst_no_result", 32'(got_q.size()), 32'd0);
    send(16'd7);
    drain();
    chk("post_rst_bcd", 32'(bcd), 32'h00007);

    for (int i = 0; i < 20; i++) begin
      r = 16'($urandom_range(0, 65535));
      send(r);
      drain();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
